// File: rtl/pulse_blinker_pkg.sv
// pulse_blinker shared types and constants.
// Timing defaults are in cycles of the 12 MHz system clock.
package pulse_blinker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int CNT_W = 17;

  localparam int DEF_ON_CYCLES  = 120000;
  localparam int DEF_GAP_CYCLES = 120000;

endpackage

// File: rtl/pulse_blinker.sv
// Stretches one-cycle strobes into fixed-length pulses with a min gap.
// Strobes arriving mid-pulse are queued and replayed in order.
module pulse_blinker
  import pulse_blinker_pkg::*;
#(
  parameter int ON_CYCLES  = DEF_ON_CYCLES,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int PEND_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pulse_in,
  output logic              blink_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam logic [CNT_W-1:0] ON_LAST =
    CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST =
    CNT_W'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [PEND_W-1:0]  pend_n;
  logic               ovf_n;
  logic               consume;
  logic [PEND_W:0]    avail;

  assign avail = {1'b0, pending}
               + {{PEND_W{1'b0}}, pulse_in};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      pending  <= pend_n;
      overflow <= ovf_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    pend_n  = pending;
    ovf_n   = 1'b0;
    consume = 1'b0;
    unique case (1'b1)
      (state == IDLE): begin
        cnt_n = '0;
        if (avail != '0) begin
          state_n = ON;
          consume = 1'b1;
        end
      end
      (state == ON): begin
        if (cnt == ON_LAST) begin
          state_n = GAP;
          cnt_n   = '0;
        end
      end
      (state == GAP): begin
        if (cnt == GAP_LAST) begin
          cnt_n = '0;
          if (avail != '0) begin
            state_n = ON;
            consume = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase

    // A consume never grows the queue, so it cannot overflow.
    if (consume) begin
      pend_n = PEND_W'(avail - 1'b1);
    end else if (pulse_in) begin
      if (pending == PEND_MAX) begin
        ovf_n = 1'b1;
      end else begin
        pend_n = pending + 1'b1;
      end
    end
  end

  assign blink_out = (state == ON);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_pulse_blinker.sv
// Directed bench for pulse_blinker with ON=4, GAP=3, PEND_W=2.
// Each scenario records 48 cycles then checks against hand values.
module tb_pulse_blinker;

  localparam int NC = 48;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pulse_in = 1'b0;
  logic       blink_out;
  logic       busy;
  logic [1:0] pending;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  logic       blk_h [NC];
  logic       bsy_h [NC];
  logic [1:0] pnd_h [NC];
  logic       ovf_h [NC];

  pulse_blinker #(
    .ON_CYCLES (4),
    .GAP_CYCLES(3),
    .PEND_W    (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pulse_in (pulse_in),
    .blink_out(blink_out),
    .busy     (busy),
    .pending  (pending),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic logic in_rng(int c, int a, int b);
    return (c >= a) && (c <= b);
  endfunction

  task automatic run(input logic [NC-1:0] stim,
                     input int rst_at);
    rst = 1'b1;
    pulse_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < NC; c++) begin
      pulse_in = stim[c];
      rst = (c == rst_at);
      @(negedge clk);
      blk_h[c] = blink_out;
      bsy_h[c] = busy;
      pnd_h[c] = pending;
      ovf_h[c] = overflow;
      @(posedge clk);
      #1;
    end
    pulse_in = 1'b0;
    rst = 1'b0;
  endtask

  function automatic logic [NC-1:0] bits(int a, int b);
    logic [NC-1:0] v = '0;
    for (int i = a; i <= b; i++) v[i] = 1'b1;
    return v;
  endfunction

  initial begin
    logic [NC-1:0] s;
    int rises;

    // Single pulse
    s = '0; s[10] = 1'b1;
    run(s, -1);
    chk("rst_blink", 32'(blk_h[0]), 0);
    chk("rst_busy",  32'(bsy_h[0]), 0);
    chk("rst_pend",  32'(pnd_h[0]), 0);
    chk("rst_ovf",   32'(ovf_h[0]), 0);
    for (int c = 1; c < 30; c++) begin
      chk($sformatf("single_blink@%0d", c),
          32'(blk_h[c]), 32'(in_rng(c, 11, 14)));
      chk($sformatf("single_busy@%0d", c),
          32'(bsy_h[c]), 32'(in_rng(c, 11, 17)));
      chk($sformatf("single_pend@%0d", c),
          32'(pnd_h[c]), 0);
    end

    // Burst of three
    run(bits(10, 12), -1);
    for (int c = 0; c < 35; c++) begin
      chk($sformatf("burst_blink@%0d", c),
          32'(blk_h[c]),
          32'(in_rng(c, 11, 14) || in_rng(c, 18, 21)
              || in_rng(c, 25, 28)));
      chk($sformatf("burst_ovf@%0d", c),
          32'(ovf_h[c]), 0);
    end
    chk("burst_pend@12", 32'(pnd_h[12]), 1);
    chk("burst_pend@13", 32'(pnd_h[13]), 2);
    chk("burst_pend@18", 32'(pnd_h[18]), 1);
    chk("burst_pend@25", 32'(pnd_h[25]), 0);

    // Overflow
    run(bits(10, 14), -1);
    chk("ovf_pend@14", 32'(pnd_h[14]), 3);
    chk("ovf_pend@15", 32'(pnd_h[15]), 3);
    rises = 0;
    for (int c = 0; c < NC; c++) begin
      chk($sformatf("ovf_flag@%0d", c),
          32'(ovf_h[c]), 32'(c == 15));
      if (c > 0 && blk_h[c] && !blk_h[c-1]) rises++;
    end
    chk("ovf_blinks", 32'(rises), 4);
    chk("ovf_idle@40", 32'(bsy_h[40]), 0);

    // Seamless restart on last GAP cycle
    s = '0; s[10] = 1'b1; s[17] = 1'b1;
    run(s, -1);
    for (int c = 0; c < 30; c++) begin
      chk($sformatf("seam_blink@%0d", c),
          32'(blk_h[c]),
          32'(in_rng(c, 11, 14) || in_rng(c, 18, 21)));
      chk($sformatf("seam_busy@%0d", c),
          32'(bsy_h[c]), 32'(in_rng(c, 11, 24)));
    end

    // Saturated consume on last GAP cycle
    s = bits(10, 13); s[17] = 1'b1;
    run(s, -1);
    chk("satc_pend@14", 32'(pnd_h[14]), 3);
    chk("satc_blink@17", 32'(blk_h[17]), 0);
    chk("satc_blink@18", 32'(blk_h[18]), 1);
    chk("satc_pend@18", 32'(pnd_h[18]), 3);
    chk("satc_pend@25", 32'(pnd_h[25]), 2);
    for (int c = 0; c < NC; c++)
      chk($sformatf("satc_ovf@%0d", c), 32'(ovf_h[c]), 0);

    // Reset during ON with two queued
    run(bits(10, 12), 13);
    chk("mrst_blink@13", 32'(blk_h[13]), 1);
    chk("mrst_pend@13", 32'(pnd_h[13]), 2);
    for (int c = 14; c < NC; c++) begin
      chk($sformatf("mrst_blink@%0d", c), 32'(blk_h[c]), 0);
      chk($sformatf("mrst_busy@%0d", c), 32'(bsy_h[c]), 0);
      chk($sformatf("mrst_pend@%0d", c), 32'(pnd_h[c]), 0);
      chk($sformatf("mrst_ovf@%0d", c), 32'(ovf_h[c]), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_blinker.md
# pulse_blinker

Output-side counterpart to the button debouncer: it turns one-cycle event strobes into clean, human-visible pulses of fixed length, e.g. to drive an LED or an external strobe. Strobes that arrive while a pulse or gap is in progress are counted and replayed in order, each as its own pulse with a guaranteed low gap. It sits between internal control logic and FPGA output pins, on the 12 MHz system clock.

## Interface
- `ON_CYCLES`, default 120000: high time of each output pulse, in clocks (10 ms at 12 MHz); legal range 1..2^CNT_W-1.
- `GAP_CYCLES`, default 120000: minimum low time after each pulse, in clocks; legal range 1..2^CNT_W-1.
- `PEND_W`, default 4: width of the pending-event counter; at most 2^PEND_W-1 events are queued.
- `clk`  in  1  system clock (12 MHz).
- `rst`  in  1  reset; synchronous, active-high.
- `pulse_in`  in  1  event strobe; each high cycle is one event.
- `blink_out`  out  1  registered, stretched output pulse.
- `busy`  out  1  high whenever the state is not IDLE.
- `pending`  out  PEND_W  number of queued events not yet started.
- `overflow`  out  1  one-cycle flag: an event was dropped because the queue was saturated.

## Operation
- FSM states: IDLE, ON, GAP. The interval counter is CNT_W = 17 bits.
- Define avail = pending + pulse_in, evaluated before saturation.
- **IDLE**
  - If avail ≥ 1: go to ON, clear the counter, and set pending ← avail − 1.
  - Otherwise stay in IDLE.
- **ON**
  - blink_out = 1.
  - The counter counts 0..ON_CYCLES−1.
  - On the cycle where the counter equals ON_CYCLES−1: go to GAP and clear the counter.
- **GAP**
  - blink_out = 0.
  - The counter counts 0..GAP_CYCLES−1.
  - At the end of the gap: if avail ≥ 1, go to ON and consume one event (pending ← avail − 1), with no IDLE cycle in between. Otherwise go to IDLE.
- **Event accounting outside a consume cycle**
  - pending ← pending + pulse_in, saturating at 2^PEND_W−1.
  - A pulse_in that arrives while pending is saturated and is not consumed that cycle is dropped, and overflow = 1 on the next cycle.
  - On a consume cycle the net change to pending is 0 or −1, so overflow is never raised.
- blink_out and busy are registered and decoded from the state register. There are no combinational paths from inputs to outputs.
- **Reset**
  - On reset the state goes to IDLE and the counter and pending are cleared.
  - blink_out = 0, busy = 0, pending = 0, overflow = 0.
  - Reset has priority over every other event. A reset in the middle of a pulse truncates it on the next edge, and queued events are discarded.

## Timing
- Latency is one cycle: pulse_in high in cycle N from IDLE gives blink_out high in cycles N+1 .. N+ON_CYCLES.
- Back-to-back events have a pulse period of exactly ON_CYCLES + GAP_CYCLES clocks.
- busy is high from the first ON cycle through the last GAP cycle. It drops one cycle after the gap ends if nothing is pending.
- pending and overflow update on the same edge that samples pulse_in.
- The counter never wraps; the range limits on the parameters guarantee this.

## Structure
- Shared package contents:
  - the state enum (IDLE/ON/GAP);
  - `CNT_W = 17`;
  - the default timing constants, in cycles at 12 MHz.
- Single flat module; no sub-module is needed. The counter and the pending register are inline.
- Estimated size is about 150 lines of RTL including parameter checks.

## Test plan
All scenarios use ON_CYCLES=4, GAP_CYCLES=3, PEND_W=2, with reset released before cycle 0.
- **Single pulse:** pulse_in high at cycle 10 → blink_out high in cycles 11–14; busy high in cycles 11–17 and low at 18; pending stays 0.
- **Burst:** pulse_in high at cycles 10, 11, 12 → blinks at 11–14, 18–21 and 25–28; pending reads 1 at 12, 2 at 13, 1 at 18 and 0 at 25.
- **Overflow:** pulses at cycles 10, 11, 12, 13, 14 → pending saturates at 3 from cycle 14; overflow is high for cycle 15 only; exactly 4 blinks occur.
- **Seamless restart:** pending = 0 and pulse_in high on the last GAP cycle → ON on the next cycle; busy never drops.
- **Saturated consume:** pending = 3 and pulse_in high on the last GAP cycle → new pulse starts, pending stays 3, overflow stays 0.
- **Mid-operation reset:** rst high during ON with pending = 2 → on the next cycle blink_out, busy, pending and overflow are all 0, and no further blinks occur without new input.
